pwm_breath_multi: RTL and testbench



---
 rtl/pwm_breath_multi.sv | 161 ++++++++++++++++
 tb/tb_pwm_breath_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_multi.sv
// pwm_breath_multi: multi-channel breathing-LED PWM.
// One shared period counter feeds CH_NUM per-channel duty/direction engines.
// Each engine ramps its duty triangularly (breath) or holds a host value
// (static). Host writes land in a shadow register and are committed only
// on a period boundary, so the PWM waveform never glitches mid-period.
// Optional macro PWM_BREATH_PHASE_EN: reset duty of channel i becomes
// (i*PERIOD)/CH_NUM so breathing channels are staggered in phase.

// Per-channel duty/direction engine with shadowed host writes.
module pwm_breath_ch #(
    parameter int              CNT_W    = 16,
    parameter int              PERIOD   = 50000,
    parameter int              STEP_UP  = 50,
    parameter int              STEP_DN  = 25,
    parameter logic [CNT_W-1:0] RST_DUTY = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             mode,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [CNT_W-1:0] cnt,
    output logic             led
);
    localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);
    localparam logic [CNT_W:0]   UP  = (CNT_W+1)'(STEP_UP);
    localparam logic [CNT_W-1:0] DN  = CNT_W'(STEP_DN);

    logic [CNT_W-1:0] duty_q, duty_d, shadow_q, shadow_d;
    logic             dir_q, dir_d;   // 0 = rising, 1 = falling
    logic             pend_q, pend_d;
    logic             led_q;
    logic [CNT_W:0]   sum;

    // Next-state: commit pending write or take one ramp step at the tick;
    // capture host writes into the shadow (tick sees the old pending/shadow).
    always_comb begin
        duty_d   = duty_q;
        dir_d    = dir_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        sum      = {1'b0, duty_q} + UP;
        if (tick) begin
            if (pend_q) begin
                duty_d = shadow_q;
                pend_d = 1'b0;
            end else if (!mode) begin
                if (!dir_q) begin
                    if (sum >= {1'b0, PER}) begin
                        duty_d = PER;
                        dir_d  = 1'b1;
                    end else begin
                        duty_d = sum[CNT_W-1:0];
                    end
                end else begin
                    if (duty_q <= DN) begin
                        duty_d = '0;
                        dir_d  = 1'b0;
                    end else begin
                        duty_d = duty_q - DN;
                    end
                end
            end
        end
        if (wr) begin
            shadow_d = (wr_duty > PER) ? PER : wr_duty;
            pend_d   = 1'b1;
        end
    end

    // Channel state and registered PWM compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q   <= RST_DUTY;
            dir_q    <= 1'b0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            led_q    <= en && (cnt >= duty_q);
        end
    end

    assign led = led_q;
endmodule

// Top: shared period counter plus an array of channel engines.
module pwm_breath_multi #(
    parameter  int CH_NUM  = 4,
    parameter  int CNT_W   = 16,
    parameter  int PERIOD  = 50000,
    parameter  int STEP_UP = 50,
    parameter  int STEP_DN = 25,
    localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic [CH_NUM-1:0] mode,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic [CH_NUM-1:0] led,
    output logic              period_tick
);
    localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             period_tick_q;

    assign tick = (cnt_q == PER) && en;

    // Counter advances only while enabled; wraps after PERIOD.
    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = (cnt_q == PER) ? '0 : cnt_q + CNT_W'(1);
    end

    // Period counter and registered period marker.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            period_tick_q <= tick;
        end
    end

    assign period_tick = period_tick_q;

    for (genvar g = 0; g < CH_NUM; g++) begin : gen_ch
`ifdef PWM_BREATH_PHASE_EN
        localparam longint RDV = (longint'(g) * longint'(PERIOD)) / longint'(CH_NUM);
        localparam logic [CNT_W-1:0] RD = CNT_W'(RDV);
`else
        localparam logic [CNT_W-1:0] RD = '0;
`endif
        pwm_breath_ch #(
            .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP_UP(STEP_UP),
            .STEP_DN(STEP_DN), .RST_DUTY(RD)
        ) u_ch (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .en      (en),
            .tick    (tick),
            .mode    (mode[g]),
            .wr      (cfg_wr && (cfg_ch == CH_W'(g))),
            .wr_duty (cfg_duty),
            .cnt     (cnt_q),
            .led     (led[g])
        );
    end
endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi (CH_NUM=3, PERIOD=9, STEP_UP=3, STEP_DN=2).
// Duty is observed from the pins: over one period window the number of
// clocks with led high equals PERIOD+1-duty.
module tb_pwm_breath_multi;
    localparam int CH = 3;
    localparam int W  = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic [CH-1:0] mode;
    logic          cfg_wr;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_duty;
    logic [CH-1:0] led;
    logic          period_tick;

    pwm_breath_multi #(
        .CH_NUM(CH), .CNT_W(W), .PERIOD(9), .STEP_UP(3), .STEP_DN(2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .en          (en),
        .mode        (mode),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_duty    (cfg_duty),
        .led         (led),
        .period_tick (period_tick)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      tag;
        logic [2:0] mask;
        int         h0, h1, h2;
    } exp_t;

    exp_t sb[$];
    int   nerr = 0;
    int   nchk = 0;

`ifdef PWM_BREATH_PHASE_EN
    localparam logic [2:0] LOCK = 3'b001;
`else
    localparam logic [2:0] LOCK = 3'b111;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] mask,
                        input int h0, input int h1, input int h2);
        exp_t e;
        e.tag = tag; e.mask = mask; e.h0 = h0; e.h1 = h1; e.h2 = h2;
        sb.push_back(e);
    endtask

    // One period window starting at a cnt==0 negedge; optional write
    // visible at the posedge following sample index wr_at (0 = first).
    task automatic measure(input int wr_at, input logic [1:0] ch, input logic [W-1:0] dv);
        exp_t e;
        int   hi [3];
        int   eh [3];
        int   bad;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e   = sb.pop_front();
        eh  = '{e.h0, e.h1, e.h2};
        hi  = '{0, 0, 0};
        bad = 0;
        cfg_ch   = ch;
        cfg_duty = dv;
        cfg_wr   = (wr_at == 0);
        for (int j = 1; j <= 10; j++) begin
            @(negedge sys_clk);
            for (int i = 0; i < CH; i++) hi[i] += int'(led[i]);
            if (period_tick !== (j == 10)) bad++;
            cfg_wr = (j == wr_at);
        end
        for (int i = 0; i < CH; i++)
            if (e.mask[i]) chk($sformatf("%s_ch%0d_hi", e.tag, i), hi[i], eh[i]);
        chk($sformatf("%s_tick", e.tag), bad, 0);
    endtask

    initial begin
        int n, h, bad;
        sys_rst_n = 1'b0; en = 1'b0; mode = '0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_duty = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_led", int'(led), 0);
        chk("rst_tick", int'(period_tick), 0);

        // Reset duty window, then breath ramp 3,6,9,7,5,3,1,0,3.
        sys_rst_n = 1'b1; en = 1'b1;
`ifdef PWM_BREATH_PHASE_EN
        push("w0", 3'b111, 10, 7, 4);
`else
        push("w0", 3'b111, 10, 10, 10);
`endif
        measure(-1, 0, 0);
        push("w1", LOCK, 7, 7, 7);   measure(-1, 0, 0);
        push("w2", LOCK, 4, 4, 4);   measure(-1, 0, 0);
        push("w3", LOCK, 1, 1, 1);   measure(-1, 0, 0);
        push("w4", LOCK, 3, 3, 3);   measure(-1, 0, 0);
        push("w5", LOCK, 5, 5, 5);   measure(-1, 0, 0);
        push("w6", LOCK, 7, 7, 7);   measure(-1, 0, 0);
        push("w7", LOCK, 9, 9, 9);   measure(-1, 0, 0);
        push("w8", LOCK, 10, 10, 10); measure(-1, 0, 0);
        push("w9", LOCK, 7, 7, 7);   measure(-1, 0, 0);

        // ch1 static, write 20 (clamps to 9): old duty until next tick.
        mode = 3'b010;
        push("w10", LOCK, 4, 4, 4);  measure(0, 2'd1, 8'd20);
        push("w11", LOCK | 3'b010, 1, 1, 1);
        measure(-1, 0, 0);
        // Write in the tick cycle lands one period later.
        push("w12", LOCK | 3'b010, 3, 1, 3);
        measure(9, 2'd1, 8'd4);
        // Out-of-range channel write is ignored.
        push("w13", LOCK | 3'b010, 5, 1, 5);
        measure(0, 2'd3, 8'd0);
        // Breath channel written mid-ramp while falling.
        push("w14", LOCK | 3'b010, 7, 6, 7);
        measure(0, 2'd0, 8'd5);
        push("w15", LOCK | 3'b010, 5, 6, 9);
        measure(-1, 0, 0);
        // Back to breath: ch1 resumes from duty 4 rising.
        mode = 3'b000;
        push("w16", LOCK | 3'b010, 7, 6, 10);
        measure(-1, 0, 0);
        push("w17", LOCK, 9, 3, 7);
        measure(-1, 0, 0);

        // Freeze with en=0 at cnt==3 for 7 clocks.
        repeat (3) @(negedge sys_clk);
        en  = 1'b0;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge sys_clk);
            if (led !== 3'b000 || period_tick !== 1'b0) bad++;
        end
        chk("en0_off", bad, 0);
        en = 1'b1;
        n = 0; h = 0;
        do begin
            @(negedge sys_clk);
            n++;
            h += int'(led[0]);
        end while (period_tick !== 1'b1 && n < 20);
        chk("resume_len", n, 7);
        chk("resume_led0", h, 7);
        push("w19", 3'b001, 7, 0, 0);
        measure(-1, 0, 0);

        // Reset mid-ramp overrides a same-cycle write.
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_duty = 8'd7;
        @(negedge sys_clk);
        chk("rstm_led", int'(led), 0);
        chk("rstm_tick", int'(period_tick), 0);
        sys_rst_n = 1'b1; cfg_wr = 1'b0;
`ifdef PWM_BREATH_PHASE_EN
        push("r0", 3'b111, 10, 7, 4);
        push("r1", 3'b111, 7, 4, 1);
`else
        push("r0", 3'b111, 10, 10, 10);
        push("r1", 3'b111, 7, 7, 7);
`endif
        measure(-1, 0, 0);
        measure(-1, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
